i2c_config_seq: RTL and testbench

Sequencer that pushes a fixed table of 16-bit configuration words, such as codec register writes, through the existing I2C master one transfer at a time.
It drives the master's start/data inputs and watches its busy output.
It inserts a programmable gap between transfers and reports done or timeout error.
It sits between the board top level (CLOCK_50 domain) and the I2C instance.

---
 rtl/i2c_config_seq_pkg.sv | 13 +
 rtl/i2c_config_seq_if.sv | 8 +
 rtl/i2c_config_seq_rom.sv | 16 +
 rtl/i2c_config_seq.sv | 90 +++++++++
 tb/tb_i2c_config_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/i2c_config_seq_pkg.sv
// i2c_cfg_pkg: shared word width, state encoding and configuration table for the I2C sequencer
package i2c_cfg_pkg;
  localparam int CFG_WORD_W = 16;
  localparam int CFG_N = 3;
  localparam logic [CFG_N-1:0][CFG_WORD_W-1:0] CFG_TABLE = {16'h1E00, 16'h0A5F, 16'h1234};
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;
endpackage

// File: rtl/i2c_config_seq_if.sv
// i2c_config_seq_if: start/data/busy handshake between the sequencer and the I2C master
interface i2c_config_seq_if;
  logic start;
  logic [i2c_cfg_pkg::CFG_WORD_W-1:0] data;
  logic busy;
  modport master (output start, output data, input busy);
  modport slave (input start, input data, output busy);
endinterface

// File: rtl/i2c_config_seq_rom.sv
// i2c_config_rom: index-to-word lookup into the package table, zero outside the table
module i2c_config_rom
  import i2c_cfg_pkg::*;
#(
  parameter int N_REGS = 3,
  parameter int IW = 2
) (
  input  logic [IW-1:0]         idx,
  output logic [CFG_WORD_W-1:0] word
);
  always_comb begin
    word = '0;
    for (int i = 0; i < CFG_N; i++)
      if (i < N_REGS && int'(idx) == i) word = CFG_TABLE[i];
  end
endmodule

// File: rtl/i2c_config_seq.sv
// i2c_config_seq: walks the configuration table through the I2C master, one gated transfer at a time
module i2c_config_seq
  import i2c_cfg_pkg::*;
#(
  parameter int N_REGS = 3,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IW = N_REGS > 1 ? $clog2(N_REGS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 go,
  i2c_config_seq_if.master     i2c,
  output logic [IW-1:0]        idx,
  output logic                 active,
  output logic                 done,
  output logic                 err
);
  localparam int CMAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW = CMAX > 0 ? $clog2(CMAX + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GLAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  logic [2:0] state;
  logic [CW-1:0] cnt, cnt_inc;
  logic [CFG_WORD_W-1:0] word;
  logic last;
  i2c_config_rom #(.N_REGS(N_REGS), .IW(IW)) rom (.idx(idx), .word(word));
  always_comb cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_comb last = idx == IW'(N_REGS - 1);
  // start is raised on LOAD exit so a busy already high in REQ yields a one-cycle pulse
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= ST_IDLE;
      cnt <= '0;
      idx <= '0;
      active <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      i2c.start <= 1'b0;
      i2c.data <= '0;
    end else
      case (state)
        ST_IDLE, ST_DONE, ST_ERR:
          if (go) begin
            done <= 1'b0;
            err <= 1'b0;
            idx <= '0;
            active <= 1'b1;
            state <= ST_LOAD;
          end
        ST_LOAD: begin
          i2c.data <= word;
          i2c.start <= 1'b1;
          cnt <= '0;
          state <= ST_REQ;
        end
        ST_REQ:
          if (i2c.busy) begin
            i2c.start <= 1'b0;
            cnt <= '0;
            state <= ST_WAIT;
          end else if (cnt == TLAST) begin
            i2c.start <= 1'b0;
            err <= 1'b1;
            active <= 1'b0;
            state <= ST_ERR;
          end else cnt <= cnt_inc;
        ST_WAIT:
          if (!i2c.busy) begin
            cnt <= '0;
            state <= ST_GAP;
          end else if (cnt == TLAST) begin
            err <= 1'b1;
            active <= 1'b0;
            state <= ST_ERR;
          end else cnt <= cnt_inc;
        ST_GAP:
          if (cnt == GLAST) begin
            if (last) begin
              done <= 1'b1;
              active <= 1'b0;
              state <= ST_DONE;
            end else begin
              idx <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end else cnt <= cnt_inc;
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_i2c_config_seq.sv
// tb_i2c_config_seq: directed checks of a 3-word run with a bus model and a 1-word unit driven by hand
module tb_i2c_config_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go_a = 1'b0;
  logic go_b = 1'b0;
  logic [1:0] idx_a;
  logic [0:0] idx_b;
  logic act_a, done_a, err_a, act_b, done_b, err_b;
  int n_chk = 0;
  int n_err = 0;
  int d_a, h_a;
  int rise_t[$];
  logic [15:0] rise_d[$];
  int drop_t, done_t;
  always #5 clk = ~clk;
  i2c_config_seq_if ia ();
  i2c_config_seq_if ib ();
  i2c_config_seq #(.N_REGS(3), .GAP_CYCLES(4), .TIMEOUT_CYCLES(25)) dut_a (
    .CLK(clk), .RST(rst_n), .go(go_a), .i2c(ia.master),
    .idx(idx_a), .active(act_a), .done(done_a), .err(err_a));
  i2c_config_seq #(.N_REGS(1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(10)) dut_b (
    .CLK(clk), .RST(rst_n), .go(go_b), .i2c(ib.master),
    .idx(idx_b), .active(act_b), .done(done_b), .err(err_b));
  // bus model: busy rises two cycles after start is seen and stays high 20 cycles
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ia.busy <= 1'b0;
      d_a <= 0;
      h_a <= 0;
    end else if (ia.busy) begin
      h_a <= h_a + 1;
      if (h_a == 19) ia.busy <= 1'b0;
    end else if (ia.start) begin
      if (d_a == 1) begin
        ia.busy <= 1'b1;
        h_a <= 0;
        d_a <= 0;
      end else d_a <= d_a + 1;
    end else d_a <= 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      chk("excl_a", 32'(done_a & err_a), 32'd0);
      chk("excl_b", 32'(done_b & err_b), 32'd0);
    end
  task automatic run_a(input int g1, input int g2, input int len);
    logic prev = 1'b0;
    rise_t.delete();
    rise_d.delete();
    drop_t = -1;
    done_t = -1;
    @(negedge clk);
    go_a = 1'b1;
    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      go_a = (t == g1) || (t == g2);
      if (ia.start && !prev) begin
        rise_t.push_back(t);
        rise_d.push_back(ia.data);
      end
      if (!ia.start && prev && drop_t < 0) drop_t = t;
      if (done_a && done_t < 0) done_t = t;
      prev = ia.start;
    end
    go_a = 1'b0;
  endtask
  task automatic check_a(input string s);
    chk({s, "_nrise"}, 32'(rise_t.size()), 32'd3);
    if (rise_t.size() == 3) begin
      chk({s, "_rise0"}, 32'(rise_t[0]), 32'd2);
      chk({s, "_data0"}, 32'(rise_d[0]), 32'h1234);
      chk({s, "_rise1"}, 32'(rise_t[1]), 32'd30);
      chk({s, "_data1"}, 32'(rise_d[1]), 32'h0A5F);
      chk({s, "_rise2"}, 32'(rise_t[2]), 32'd58);
      chk({s, "_data2"}, 32'(rise_d[2]), 32'h1E00);
    end
    chk({s, "_drop0"}, 32'(drop_t), 32'd5);
    chk({s, "_done_t"}, 32'(done_t), 32'd85);
    chk({s, "_done"}, 32'(done_a), 32'd1);
    chk({s, "_err"}, 32'(err_a), 32'd0);
    chk({s, "_act"}, 32'(act_a), 32'd0);
    chk({s, "_idx"}, 32'(idx_a), 32'd2);
    chk({s, "_hold"}, 32'(ia.data), 32'h1E00);
  endtask
  initial begin
    int hi;
    logic stuck;
    ib.busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(ia.start), 32'd0);
    chk("rst_data", 32'(ia.data), 32'd0);
    chk("rst_idx", 32'(idx_a), 32'd0);
    chk("rst_act", 32'(act_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    rst_n = 1'b1;
    run_a(-1, -1, 100);
    check_a("s1");
    run_a(3, 26, 100);
    check_a("s4");
    run_a(-1, -1, 40);
    chk("mid_busy", 32'(ia.busy), 32'd1);
    chk("mid_idx", 32'(idx_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_start", 32'(ia.start), 32'd0);
    chk("ar_act", 32'(act_a), 32'd0);
    chk("ar_done", 32'(done_a), 32'd0);
    chk("ar_err", 32'(err_a), 32'd0);
    chk("ar_idx", 32'(idx_a), 32'd0);
    chk("ar_data", 32'(ia.data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_a(-1, -1, 100);
    check_a("s5");
    hi = 0;
    @(negedge clk);
    go_b = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      @(negedge clk);
      go_b = 1'b0;
      hi += int'(ib.start);
      if (t == 11) begin
        chk("to_start11", 32'(ib.start), 32'd1);
        chk("to_err11", 32'(err_b), 32'd0);
      end
      if (t == 12) begin
        chk("to_start12", 32'(ib.start), 32'd0);
        chk("to_err12", 32'(err_b), 32'd1);
        chk("to_done", 32'(done_b), 32'd0);
        chk("to_idx", 32'(idx_b), 32'd0);
        chk("to_act", 32'(act_b), 32'd0);
      end
    end
    chk("to_hi", 32'(hi), 32'd10);
    stuck = 1'b0;
    @(negedge clk);
    go_b = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      go_b = 1'b0;
      if (t == 1) begin
        chk("rs_err", 32'(err_b), 32'd0);
        chk("rs_act", 32'(act_b), 32'd1);
      end
      if (t == 4) ib.busy = 1'b1;
      if (t >= 5) stuck |= ib.start;
      if (t == 14) chk("wt_err14", 32'(err_b), 32'd0);
      if (t == 15) begin
        chk("wt_err15", 32'(err_b), 32'd1);
        chk("wt_done", 32'(done_b), 32'd0);
      end
    end
    chk("wt_nostart", 32'(stuck), 32'd0);
    ib.busy = 1'b0;
    @(negedge clk);
    go_b = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      go_b = 1'b0;
      if (t == 1) ib.busy = 1'b1;
      if (t == 2) chk("pre_start2", 32'(ib.start), 32'd1);
      if (t == 3) chk("pre_start3", 32'(ib.start), 32'd0);
      if (t == 6) ib.busy = 1'b0;
      if (t == 7) chk("pre_done7", 32'(done_b), 32'd0);
      if (t == 8) begin
        chk("pre_done8", 32'(done_b), 32'd1);
        chk("pre_err", 32'(err_b), 32'd0);
        chk("pre_act", 32'(act_b), 32'd0);
        chk("pre_idx", 32'(idx_b), 32'd0);
        chk("pre_data", 32'(ib.data), 32'h1234);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
